hs32_mem_arb: RTL

Two-master arbiter sitting directly upstream of the BRAM controller's single CPU-side port (addr/dwrite/rw/stb, ack/dread). It multiplexes the HS32 core's memory port and the Caravel management Wishbone slave port onto that one port, using round-robin grant. It registers every transaction and adds a watchdog so a missing memory ack cannot hang either master.

---
 rtl/hs32_mem_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: round-robin arbiter placing the HS32 core memory port and the
// Caravel management Wishbone slave onto the single CPU-side BRAM controller
// port. Every transaction is registered, and a watchdog answers with an error
// if the memory never acknowledges.
module hs32_mem_arb #(
  parameter int unsigned addr_width = 12,
  parameter int unsigned timeout    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [addr_width-1:0] i_cpu_addr,
  input  logic [31:0]           i_cpu_dwrite,
  input  logic                  i_cpu_rw,
  input  logic                  i_cpu_stb,
  output logic                  o_cpu_ack,
  output logic [31:0]           o_cpu_dread,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [addr_width-1:0] i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  output logic                  o_wb_ack,
  output logic [31:0]           o_wb_dat,
  output logic [addr_width-1:0] o_mem_addr,
  output logic [31:0]           o_mem_dwrite,
  output logic                  o_mem_rw,
  output logic                  o_mem_stb,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_dread,
  output logic                  o_err
);

  localparam logic [3:0] TMO = 4'(timeout);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic        owner;        // 0 = CPU, 1 = Wishbone
  logic        last_grant;   // 0 = CPU, 1 = Wishbone
  logic        suppressed;   // Wishbone dropped cyc during its transaction
  logic [3:0]  wdog_cnt;
  logic        cpu_req, wb_req;
  logic        grant, grant_wb, wdog_hit, abort_now;
  logic [31:0] resp_data;

  assign cpu_req   = i_cpu_stb;
  assign wb_req    = i_wb_cyc & i_wb_stb;
  assign abort_now = owner & ~i_wb_cyc;
  assign resp_data = wdog_hit ? '0 : i_mem_dread;

  // Next-state logic and round-robin grant decision
  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    grant_wb = 1'b0;
    wdog_hit = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req | wb_req) begin
          grant    = 1'b1;
          grant_wb = wb_req & (~cpu_req | ~last_grant);
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_mem_ack) begin
          state_d = RESP;
        end else if (wdog_cnt == TMO) begin
          wdog_hit = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_d;
  end

  // Transaction latches, watchdog and registered outputs.
  // Strobe, acks, err and response data are loaded on the edge entering
  // ISSUE/RESP so they are valid exactly while the FSM sits in those states.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      suppressed   <= 1'b0;
      wdog_cnt     <= '0;
      o_mem_stb    <= 1'b0;
      o_mem_rw     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_dwrite <= '0;
      o_cpu_ack    <= 1'b0;
      o_wb_ack     <= 1'b0;
      o_cpu_dread  <= '0;
      o_wb_dat     <= '0;
      o_err        <= 1'b0;
    end else begin
      o_mem_stb <= 1'b0;
      o_cpu_ack <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_err     <= 1'b0;
      case (state)
        IDLE: begin
          suppressed <= 1'b0;
          if (grant) begin
            owner        <= grant_wb;
            o_mem_stb    <= 1'b1;
            o_mem_addr   <= grant_wb ? i_wb_adr : i_cpu_addr;
            o_mem_dwrite <= grant_wb ? i_wb_dat : i_cpu_dwrite;
            o_mem_rw     <= grant_wb ? i_wb_we  : i_cpu_rw;
          end
        end
        ISSUE: begin
          wdog_cnt <= '0;
          if (abort_now) suppressed <= 1'b1;
        end
        WAIT: begin
          if (abort_now) suppressed <= 1'b1;
          if (state_d == RESP) begin
            o_err <= wdog_hit;
            if (owner) begin
              o_wb_dat <= resp_data;
              o_wb_ack <= ~(suppressed | abort_now);
            end else begin
              o_cpu_dread <= resp_data;
              o_cpu_ack   <= 1'b1;
            end
          end else begin
            wdog_cnt <= wdog_cnt + 4'd1;
          end
        end
        RESP:    last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule
